bank_buffer: RTL and testbench
==============================

# bank_buffer

Four-bank sample buffer that sits directly downstream of the address counter. It consumes the counter's 9-bit count as a write address and stores one data word per enabled cycle: bits [6:0] select the word and bits [8:7] select the bank. Each bank becomes readable once its last word (address 127) is written. A read-side state machine then streams completed banks out in bank order over a valid/ready handshake.

## Interface
- RAM_ADDR_WIDTH, 7: word address width; bank depth = 2^RAM_ADDR_WIDTH.
- DATA_WIDTH, 16: sample width.
- clk  in  1  clock; all logic on rising edge.
- asyn_reset  in  1  reset: asynchronous, active-high.
- wr_en  in  1  write strobe; same signal that drives the counter's enable.
- cnt  in  RAM_ADDR_WIDTH+2  counter value paired with wr_en: [6:0] word, [8:7] bank.
- wr_data  in  DATA_WIDTH  sample written when wr_en=1.
- rd_ready  in  1  downstream accepts rd_data.
- rd_valid  out  1  rd_data/rd_bank/rd_addr are valid.
- rd_data  out  DATA_WIDTH  word read from the buffer.
- rd_bank  out  2  bank being drained.
- rd_addr  out  RAM_ADDR_WIDTH  word index of rd_data.
- rd_last  out  1  high with the word at rd_addr=127.
- overflow  out  1  sticky: a write targeted a full bank.
- parity_err  out  1  sticky parity error (only when the parity macro is defined).

## Operation
- Storage is a 512 x DATA_WIDTH array, indexed by cnt directly. It is not reset.
- Write: when wr_en=1 and full[cnt[8:7]]=0, the block writes mem[cnt] <= wr_data.
  - If that write has cnt[6:0]=127, full[cnt[8:7]] is set.
- Write to a full bank: the write is dropped and overflow is set. It stays set until reset.
- Each bank has one full flag, full[3:0]. The reader services banks strictly in order 0,1,2,3,0…, using its own 2-bit pointer rd_ptr.
- Read FSM states: IDLE, FETCH, HOLD.
  - IDLE: if full[rd_ptr]=1, clear the word index ridx to 0 and go to FETCH.
  - FETCH: issue a synchronous RAM read of {rd_ptr, ridx}; go to HOLD next cycle.
  - HOLD: rd_valid=1. On rd_ready=1:
    - if ridx=127: clear full[rd_ptr], increment rd_ptr, go to IDLE;
    - otherwise: increment ridx and go to FETCH.
- Outputs rd_data, rd_bank and rd_addr hold stable while rd_valid=1 and rd_ready=0.
- Same-cycle events:
  - The writer setting full[b] and the reader clearing full[a] in one cycle never conflict, because a write to a full bank is dropped. Both updates apply.
  - A write to bank b in the same cycle the reader clears full[b] is dropped and flagged as overflow. The clear is applied after the full check.
- Reset mid-operation:
  - full, rd_ptr, ridx and overflow return to 0; the FSM returns to IDLE.
  - Any bank being drained is abandoned. Memory contents are left as they are but are unreachable until rewritten.

## Timing
- Reset values: rd_valid=0, rd_data=0, rd_bank=0, rd_addr=0, rd_last=0, overflow=0, parity_err=0.
- Write to readable: the write at address 127 in cycle N sets full in N+1. IDLE sees it in N+1, FETCH runs in N+2, and rd_valid rises in N+3.
- Read throughput: at most 1 word per 2 cycles. A full bank takes at least 256 cycles to drain.
- wr_en and cnt are sampled in the same edge. The counter holds 0 for the first two cycles after reset; those cycles carry no wr_en.

## Configuration
- BANK_BUFFER_PARITY_EN defined:
  - Each RAM word gets one extra bit storing the even parity of wr_data.
  - On every HOLD handshake the stored parity is checked against rd_data. A mismatch sets parity_err, which is sticky until reset.
- Not defined: no parity bit is stored and parity_err is tied to 0.

## Structure
- The shared package bank_buffer_pkg holds:
  - the read-FSM state typedef (IDLE, FETCH, HOLD);
  - BANK_COUNT=4 and BANK_SEL_WIDTH=2;
  - the last-word constant 2^RAM_ADDR_WIDTH-1.
- One sub-module, bank_buffer_ram: single write port and single synchronous read port, with width DATA_WIDTH plus an optional parity bit.

## Test plan
- Write 128 words to bank 0 (cnt 0..127, data = cnt), rd_ready=1 → rd_valid rises 3 cycles after the last write. Then 128 words with rd_data=rd_addr=0..127 and rd_bank=0; rd_last is high only at 127.
- Fill banks 0 and 1 back-to-back; drain with rd_ready toggling 1/0 each cycle → bank 0 is read fully before bank 1, and data is held stable whenever rd_ready=0.
- Fill all 4 banks with rd_ready=0, then write cnt=5 (bank 0) → the write is dropped, overflow=1, and bank 0 still reads its original word 5.
- Assert asyn_reset mid-drain at rd_addr=40 → all outputs are 0 immediately, and after release rd_valid stays 0 until bank 0 is refilled.
- With BANK_BUFFER_PARITY_EN defined, force a bit flip in bank_buffer_ram at word 10 → parity_err rises on the handshake of rd_addr=10 and stays high.

Source files
------------

// File: rtl/bank_buffer_pkg.sv
`default_nettype none
// ============================================================================
// bank_buffer_pkg
// Shared read-FSM encoding, bank geometry and last-word helper.
// Rev 1.0
// ============================================================================
package bank_buffer_pkg;

  localparam int BANK_COUNT     = 4;
  localparam int BANK_SEL_WIDTH = 2;

  typedef logic [1:0] rd_state_t;
  localparam rd_state_t ST_IDLE  = 2'd0;
  localparam rd_state_t ST_FETCH = 2'd1;
  localparam rd_state_t ST_HOLD  = 2'd2;

  function automatic int last_word(input int addr_width);
    return (1 << addr_width) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bank_buffer_ram.sv
`default_nettype none
// ============================================================================
// bank_buffer_ram
// One write port, one registered read port; contents are never reset.
// Rev 1.0
// ============================================================================
module bank_buffer_ram #(
  parameter int ADDR_WIDTH = 9,
  parameter int WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (re)
      rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/bank_buffer.sv
`default_nettype none
// ============================================================================
// bank_buffer
// Four-bank sample buffer drained in bank order over valid/ready.
// Optional stored-parity checking: define BANK_BUFFER_PARITY_EN.
// Rev 1.0
// ============================================================================
module bank_buffer
  import bank_buffer_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 7,
  parameter int DATA_WIDTH     = 16
) (
  input  logic                                 clk,
  input  logic                                 asyn_reset,
  input  logic                                 wr_en,
  input  logic [RAM_ADDR_WIDTH+BANK_SEL_WIDTH-1:0] cnt,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  input  logic                                 rd_ready,
  output logic                                 rd_valid,
  output logic [DATA_WIDTH-1:0]                rd_data,
  output logic [BANK_SEL_WIDTH-1:0]            rd_bank,
  output logic [RAM_ADDR_WIDTH-1:0]            rd_addr,
  output logic                                 rd_last,
  output logic                                 overflow,
  output logic                                 parity_err
);

  localparam int CNT_W = RAM_ADDR_WIDTH + BANK_SEL_WIDTH;
  localparam logic [RAM_ADDR_WIDTH-1:0] LAST_IDX = RAM_ADDR_WIDTH'(last_word(RAM_ADDR_WIDTH));
`ifdef BANK_BUFFER_PARITY_EN
  localparam int RAM_WIDTH = DATA_WIDTH + 1;
`else
  localparam int RAM_WIDTH = DATA_WIDTH;
`endif

  rd_state_t                   state;
  logic [BANK_COUNT-1:0]       full;
  logic [BANK_COUNT-1:0]       full_nxt;
  logic [BANK_SEL_WIDTH-1:0]   rd_ptr;
  logic [RAM_ADDR_WIDTH-1:0]   ridx;
  logic [RAM_WIDTH-1:0]        ram_wdata;
  logic [RAM_WIDTH-1:0]        ram_q;

  logic [BANK_SEL_WIDTH-1:0]   wr_bank;
  logic [RAM_ADDR_WIDTH-1:0]   wr_word;
  logic                        wr_ok;
  logic                        handshake;
  logic                        drain_done;

  assign wr_bank    = cnt[CNT_W-1:RAM_ADDR_WIDTH];
  assign wr_word    = cnt[RAM_ADDR_WIDTH-1:0];
  assign wr_ok      = wr_en && !full[wr_bank];
  assign handshake  = (state == ST_HOLD) && rd_ready;
  assign drain_done = handshake && (ridx == LAST_IDX);

`ifdef BANK_BUFFER_PARITY_EN
  assign ram_wdata = {^wr_data, wr_data};
`else
  assign ram_wdata = wr_data;
`endif

  bank_buffer_ram #(
    .ADDR_WIDTH (CNT_W),
    .WIDTH      (RAM_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (cnt),
    .wdata (ram_wdata),
    .re    (state == ST_FETCH),
    .raddr ({rd_ptr, ridx}),
    .rdata (ram_q)
  );

  // Writer and reader never target the same bank in one cycle: the writer
  // only touches empty banks and the reader only clears full ones.
  always_comb begin
    full_nxt = full;
    if (wr_ok && (wr_word == LAST_IDX))
      full_nxt[wr_bank] = 1'b1;
    if (drain_done)
      full_nxt[rd_ptr] = 1'b0;
  end

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      full     <= '0;
      overflow <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wr_en && full[wr_bank])
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state  <= ST_IDLE;
      rd_ptr <= '0;
      ridx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (full[rd_ptr]) begin
            ridx  <= '0;
            state <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_HOLD;
        ST_HOLD: begin
          if (rd_ready) begin
            if (ridx == LAST_IDX) begin
              rd_ptr <= rd_ptr + 1'b1;
              state  <= ST_IDLE;
            end else begin
              ridx  <= ridx + 1'b1;
              state <= ST_FETCH;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef BANK_BUFFER_PARITY_EN
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset)
      parity_err <= 1'b0;
    else if (handshake && ((^ram_q[DATA_WIDTH-1:0]) != ram_q[DATA_WIDTH]))
      parity_err <= 1'b1;
  end
`else
  assign parity_err = 1'b0;
`endif

  // RAM output is unreset, so it is masked outside HOLD.
  assign rd_valid = (state == ST_HOLD);
  assign rd_data  = rd_valid ? ram_q[DATA_WIDTH-1:0] : '0;
  assign rd_bank  = rd_ptr;
  assign rd_addr  = ridx;
  assign rd_last  = rd_valid && (ridx == LAST_IDX);

endmodule
`default_nettype wire

// File: tb/tb_bank_buffer.sv
`default_nettype none
// ============================================================================
// tb_bank_buffer
// Scoreboard bench for bank_buffer: expected words queued on bank completion.
// Rev 1.0
// ============================================================================
module tb_bank_buffer;

  typedef struct packed {
    logic [1:0]  bank;
    logic [6:0]  addr;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        asyn_reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [8:0]  cnt = '0;
  logic [15:0] wr_data = '0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [1:0]  rd_bank;
  logic [6:0]  rd_addr;
  logic        rd_last;
  logic        overflow;
  logic        parity_err;

  int          n_checks = 0;
  int          n_pass   = 0;
  exp_t        sb[$];
  logic [15:0] model_mem [0:511];
  logic [3:0]  model_full = '0;
  logic        model_ovf  = 1'b0;

  logic        hold_pending = 1'b0;
  logic [15:0] held_data;
  logic [1:0]  held_bank;
  logic [6:0]  held_addr;

  bank_buffer dut (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .wr_en      (wr_en),
    .cnt        (cnt),
    .wr_data    (wr_data),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_bank    (rd_bank),
    .rd_addr    (rd_addr),
    .rd_last    (rd_last),
    .overflow   (overflow),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    asyn_reset = 1'b1;
    wr_en      = 1'b0;
    sb.delete();
    model_full = '0;
    model_ovf  = 1'b0;
    repeat (2) @(posedge clk);
    #1 asyn_reset = 1'b0;
    tick();
    tick();
  endtask

  // Drives one write and mirrors it in the model; a completed bank queues
  // all 128 expected words.
  task automatic write_word(input logic [8:0] a, input logic [15:0] d);
    wr_en   = 1'b1;
    cnt     = a;
    wr_data = d;
    if (model_full[a[8:7]]) begin
      model_ovf = 1'b1;
    end else begin
      model_mem[a] = d;
      if (a[6:0] == 7'd127) begin
        model_full[a[8:7]] = 1'b1;
        for (int i = 0; i < 128; i++)
          sb.push_back({a[8:7], 7'(i), model_mem[{a[8:7], 7'(i)}]});
      end
    end
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input bit toggle);
    int n = 0;
    while ((sb.size() != 0 || rd_valid) && n < budget) begin
      if (toggle)
        rd_ready = ~rd_ready;
      tick();
      n++;
    end
    check("drain_within_budget", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (asyn_reset) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", 32'(rd_valid), 32'd1);
        check("hold_data",  32'(rd_data),  32'(held_data));
        check("hold_bank",  32'(rd_bank),  32'(held_bank));
        check("hold_addr",  32'(rd_addr),  32'(held_addr));
      end
      if (rd_valid && rd_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_word", 32'(rd_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rd_data", 32'(rd_data), 32'(e.data));
          check("rd_bank", 32'(rd_bank), 32'(e.bank));
          check("rd_addr", 32'(rd_addr), 32'(e.addr));
          check("rd_last", 32'(rd_last), 32'(e.addr == 7'd127));
          if (e.addr == 7'd127)
            model_full[e.bank] = 1'b0;
        end
      end
      hold_pending = rd_valid && !rd_ready;
      held_data = rd_data;
      held_bank = rd_bank;
      held_addr = rd_addr;
    end
  end

  initial begin
    int n;

    // Reset values
    #2;
    check("rst_valid",  32'(rd_valid),   32'd0);
    check("rst_data",   32'(rd_data),    32'd0);
    check("rst_bank",   32'(rd_bank),    32'd0);
    check("rst_addr",   32'(rd_addr),    32'd0);
    check("rst_last",   32'(rd_last),    32'd0);
    check("rst_ovf",    32'(overflow),   32'd0);
    check("rst_parity", 32'(parity_err), 32'd0);
    do_reset();

    // Single bank, data = cnt, reader always ready
    rd_ready = 1'b1;
    for (int i = 0; i < 128; i++)
      write_word(9'(i), 16'(i));
    n = 0;
    while (!rd_valid && n < 10) begin
      tick();
      n++;
    end
    check("wr_to_valid_cycles", 32'(n), 32'd2);
    wait_drain(600, 1'b0);

    // Two banks, drained with rd_ready toggling
    do_reset();
    rd_ready = 1'b0;
    for (int i = 0; i < 256; i++)
      write_word(9'(i), 16'($urandom));
    wait_drain(1500, 1'b1);

    // All banks full, then an overflowing write to bank 0 word 5
    do_reset();
    rd_ready = 1'b0;
    for (int i = 0; i < 512; i++)
      write_word(9'(i), 16'(i) ^ 16'hA5A5);
    check("ovf_before", 32'(overflow), 32'(model_ovf));
    write_word(9'd5, 16'hFFFF);
    check("ovf_after", 32'(overflow), 32'(model_ovf));
    rd_ready = 1'b1;
    wait_drain(3000, 1'b0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Reset in the middle of a drain
    do_reset();
    rd_ready = 1'b1;
    for (int i = 0; i < 128; i++)
      write_word(9'(i), 16'(i) + 16'h3000);
    n = 0;
    while (!(rd_valid && rd_addr == 7'd40) && n < 400) begin
      tick();
      n++;
    end
    check("reached_addr40", 32'(rd_addr), 32'd40);
    asyn_reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(rd_valid), 32'd0);
    check("mid_rst_data",  32'(rd_data),  32'd0);
    check("mid_rst_bank",  32'(rd_bank),  32'd0);
    check("mid_rst_addr",  32'(rd_addr),  32'd0);
    check("mid_rst_last",  32'(rd_last),  32'd0);
    check("mid_rst_ovf",   32'(overflow), 32'd0);
    do_reset();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (rd_valid)
        n++;
      tick();
    end
    check("idle_after_rst", 32'(n), 32'd0);
    for (int i = 0; i < 128; i++)
      write_word(9'(i), 16'(i) + 16'h7100);
    wait_drain(600, 1'b0);

`ifdef BANK_BUFFER_PARITY_EN
    // Corrupt stored word 10 of bank 0 before it is fetched
    do_reset();
    rd_ready = 1'b0;
    for (int i = 0; i < 128; i++)
      write_word(9'(i), 16'(i) + 16'h0200);
    dut.u_ram.mem[10] = dut.u_ram.mem[10] ^ 17'd1;
    sb[10].data = sb[10].data ^ 16'd1;
    check("parity_before", 32'(parity_err), 32'd0);
    rd_ready = 1'b1;
    wait_drain(600, 1'b0);
    check("parity_after", 32'(parity_err), 32'd1);
    repeat (5) tick();
    check("parity_sticky", 32'(parity_err), 32'd1);
`else
    check("parity_tied", 32'(parity_err), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
